// File: rtl/seg7_scan_driver_if.sv
// Frame-load and display-pin bundle for the time-multiplexed 7-segment scan driver.
// The master is the datapath side (loads frames); the slave is the driver itself.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic [NUM_DIGITS-1:0]   anodes;
  logic [6:0]              cathodes;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output value, dp_in, digit_en, load,
    input  anodes, cathodes, dp, frame_done
  );

  modport slave (
    input  value, dp_in, digit_en, load,
    output anodes, cathodes, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Scans an N-digit common-anode 7-segment display one digit per refresh slot,
// with frame-boundary loading, leading-zero blanking and anti-ghost dead time.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int LZ_BLANK    = 1
) (
  input logic          clk,
  input logic          reset_n,
  seg7_scan_driver_if.slave bus
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  logic          slot_end;
  logic          wrap;

  logic                    pend;
  logic [4*NUM_DIGITS-1:0] pend_val, act_val;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_en, act_en;

  logic [NUM_DIGITS-1:0] dark;
  logic [NUM_DIGITS-1:0] sel;
  logic                  zero_above;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_dark;
  logic                  blank;

  logic [NUM_DIGITS-1:0] anodes_r;
  logic [6:0]            cathodes_r;
  logic                  dp_r;
  logic                  frame_done_r;

  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: font = 7'b0000001;
      4'h1: font = 7'b1001111;
      4'h2: font = 7'b0010010;
      4'h3: font = 7'b0000110;
      4'h4: font = 7'b1001100;
      4'h5: font = 7'b0100100;
      4'h6: font = 7'b0100000;
      4'h7: font = 7'b0001111;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0000100;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b1100000;
      4'hC: font = 7'b0110001;
      4'hD: font = 7'b1000010;
      4'hE: font = 7'b0110000;
      default: font = 7'b0111000;
    endcase
  endfunction

  assign slot_end = (pcnt == PCNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= slot_end ? '0 : pcnt + PW'(1);
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Enables come out of reset set so the cleared frame shows a lit "0" on digit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend     <= 1'b0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_en  <= '0;
      act_val  <= '0;
      act_dp   <= '0;
      act_en   <= '1;
    end else if (wrap) begin
      if (bus.load) begin
        act_val <= bus.value;
        act_dp  <= bus.dp_in;
        act_en  <= bus.digit_en;
      end else if (pend) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        act_en  <= pend_en;
      end
      pend <= 1'b0;
    end else if (bus.load) begin
      pend_val <= bus.value;
      pend_dp  <= bus.dp_in;
      pend_en  <= bus.digit_en;
      pend     <= 1'b1;
    end
  end

  always_comb begin
    dark       = '0;
    sel        = '0;
    zero_above = 1'b1;
    cur_digit  = 4'h0;
    cur_dp     = 1'b0;
    cur_dark   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (act_val[4*k +: 4] == 4'h0);
      dark[k]    = !act_en[k] || ((LZ_BLANK != 0) && (k > 0) && zero_above);
      sel[k]     = (idx == IW'(k));
      if (sel[k]) begin
        cur_digit = act_val[4*k +: 4];
        cur_dp    = act_dp[k];
        cur_dark  = dark[k];
      end
    end
    blank = (int'(pcnt) < BLANK_CYC);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anodes_r     <= '1;
      cathodes_r   <= 7'h7F;
      dp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap;
      if (blank || cur_dark) begin
        anodes_r   <= '1;
        cathodes_r <= 7'h7F;
        dp_r       <= 1'b1;
      end else begin
        anodes_r   <= ~sel;
        cathodes_r <= font(cur_digit);
        dp_r       <= ~cur_dp;
      end
    end
  end

  assign bus.anodes     = anodes_r;
  assign bus.cathodes   = cathodes_r;
  assign bus.dp         = dp_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: per-cycle scoreboard from a frame model,
// plus directed checks for reset, loading, blanking, dead time and mid-scan reset.
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam logic [6:0] FONT [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                       7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] ca;
    logic       dp;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYC(BC), .LZ_BLANK(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Frame model
  int         m_pcnt, m_idx;
  logic       m_pend;
  logic [15:0] p_val, a_val;
  logic [3:0]  p_dp, a_dp, p_en, a_en;
  exp_t        q[$];
  logic        m_wrap;
  assign m_wrap = (m_pcnt == RD - 1) && (m_idx == N - 1);

  function automatic exp_t expect_of();
    exp_t e;
    logic d;
    d = !a_en[m_idx] || ((m_idx > 0) && ((a_val >> (4 * m_idx)) == 16'h0));
    if (m_pcnt < BC || d) begin
      e.an = 4'hF; e.ca = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an = ~(4'b0001 << m_idx);
      e.ca = FONT[a_val[4*m_idx +: 4]];
      e.dp = ~a_dp[m_idx];
    end
    e.fd = m_wrap;
    return e;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pcnt <= 0; m_idx <= 0; m_pend <= 1'b0;
      p_val <= '0; p_dp <= '0; p_en <= '0;
      a_val <= '0; a_dp <= '0; a_en <= 4'hF;
      q.delete();
    end else begin
      q.push_back(expect_of());
      if (m_wrap) begin
        if (bus.load) begin
          a_val <= bus.value; a_dp <= bus.dp_in; a_en <= bus.digit_en;
        end else if (m_pend) begin
          a_val <= p_val; a_dp <= p_dp; a_en <= p_en;
        end
        m_pend <= 1'b0;
      end else if (bus.load) begin
        p_val <= bus.value; p_dp <= bus.dp_in; p_en <= bus.digit_en;
        m_pend <= 1'b1;
      end
      m_pcnt <= (m_pcnt == RD - 1) ? 0 : m_pcnt + 1;
      if (m_pcnt == RD - 1) m_idx <= (m_idx + 1) % N;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n || q.size() == 0) begin
      e = '{an: 4'hF, ca: 7'h7F, dp: 1'b1, fd: 1'b0};
    end else begin
      e = q.pop_front();
    end
    chk("sb_anodes", 32'(bus.anodes), 32'(e.an));
    chk("sb_cathodes", 32'(bus.cathodes), 32'(e.ca));
    chk("sb_dp", 32'(bus.dp), 32'(e.dp));
    chk("sb_frame_done", 32'(bus.frame_done), 32'(e.fd));
    chk("anode_onehot", 32'($countones(~bus.anodes) <= 1), 32'd1);
  end

  task automatic wait_slot(input int k);
    logic [3:0] s;
    bit ok;
    s = ~(4'b0001 << k);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (bus.anodes === s) ok = 1'b1;
    end
    if (!ok) chk("wait_slot_timeout", 32'(k), 32'hFFFF);
  endtask

  task automatic wait_fd(output int n);
    bit ok;
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (bus.frame_done === 1'b1) ok = 1'b1;
    end
    if (!ok) chk("wait_fd_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
    bus.value = v; bus.dp_in = d; bus.digit_en = en; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    int n, cnt;
    logic [3:0] seen;
    bit ok;
    bus.value = '0; bus.dp_in = '0; bus.digit_en = '0; bus.load = 1'b0;

    // 1: reset and first digit-0 slot
    repeat (3) @(negedge clk);
    chk("rst_anodes", 32'(bus.anodes), 32'hF);
    chk("rst_cathodes", 32'(bus.cathodes), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'd1);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_dead", 32'(bus.anodes), 32'hF);
    wait_slot(0);
    chk("t1_cathodes", 32'(bus.cathodes), 32'h01);

    // 2: full four-digit frame with a decimal point
    @(negedge clk);
    do_load(16'h12AF, 4'b0100, 4'hF);
    wait_fd(n);
    wait_slot(0);
    chk("t2_d0", 32'(bus.cathodes), 32'h38);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.anodes === 4'hE) cnt++; else break;
    end
    chk("t5_lit_cycles", 32'(cnt), 32'd6);
    wait_slot(1);
    chk("t2_d1", 32'(bus.cathodes), 32'h08);
    wait_slot(2);
    chk("t2_d2", 32'(bus.cathodes), 32'h12);
    chk("t2_d2_dp", 32'(bus.dp), 32'd0);
    wait_slot(3);
    chk("t2_d3", 32'(bus.cathodes), 32'h4F);
    chk("t2_d3_dp", 32'(bus.dp), 32'd1);
    wait_fd(n);
    wait_fd(n);
    chk("t2_fd_period", 32'(n), 32'd32);

    // 3: leading-zero blanking
    do_load(16'h0050, 4'b0000, 4'hF);
    wait_fd(n);
    seen = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      seen |= ~bus.anodes;
    end
    chk("t3_lit_digits", 32'(seen), 32'h3);
    wait_slot(1);
    chk("t3_d1", 32'(bus.cathodes), 32'h24);
    wait_slot(0);
    chk("t3_d0", 32'(bus.cathodes), 32'h01);

    // 4: mid-frame load held until wrap; boundary load shown immediately
    wait_fd(n);
    @(negedge clk);
    do_load(16'h0003, 4'b0001, 4'hF);
    wait_slot(1);
    chk("t4_old_d1", 32'(bus.cathodes), 32'h24);
    wait_fd(n);
    wait_slot(0);
    chk("t4_new_d0", 32'(bus.cathodes), 32'h06);
    chk("t4_new_dp", 32'(bus.dp), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (m_pcnt == RD - 1 && m_idx == N - 1) ok = 1'b1;
    end
    if (!ok) chk("t4_boundary_timeout", 32'd0, 32'd1);
    do_load(16'h0007, 4'b0000, 4'h1);
    wait_slot(0);
    chk("t4_boundary_d0", 32'(bus.cathodes), 32'h0F);

    // 6: asynchronous reset during the digit-2 slot
    do_load(16'h0300, 4'b0000, 4'hF);
    wait_fd(n);
    wait_slot(2);
    chk("t6_d2", 32'(bus.cathodes), 32'h06);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_anodes", 32'(bus.anodes), 32'hF);
    chk("t6_rst_cathodes", 32'(bus.cathodes), 32'h7F);
    chk("t6_rst_dp", 32'(bus.dp), 32'd1);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    wait_slot(0);
    chk("t6_d0_cleared", 32'(bus.cathodes), 32'h01);
    seen = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      seen |= ~bus.anodes;
    end
    chk("t6_lit_digits", 32'(seen), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
